// File: rtl/router_pkg.sv
// Shared mesh-router definitions: port indices, crossbar select encodings,
// arbiter FSM states and small helpers used by the output arbiters.
package router_pkg;

    localparam int NUM_PORTS = 5;

    // Index order matches the round-robin rotation L -> N -> E -> W -> S.
    typedef enum logic [2:0] {
        PORT_L = 3'd0,
        PORT_N = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_S = 3'd4
    } port_t;

    localparam logic [NUM_PORTS-1:0] XSEL_N    = 5'b00001;
    localparam logic [NUM_PORTS-1:0] XSEL_E    = 5'b00010;
    localparam logic [NUM_PORTS-1:0] XSEL_W    = 5'b00100;
    localparam logic [NUM_PORTS-1:0] XSEL_S    = 5'b01000;
    localparam logic [NUM_PORTS-1:0] XSEL_L    = 5'b10000;
    localparam logic [NUM_PORTS-1:0] XSEL_NONE = 5'b00000;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

    function automatic logic [NUM_PORTS-1:0] xsel_of(port_t p);
        case (p)
            PORT_N:  return XSEL_N;
            PORT_E:  return XSEL_E;
            PORT_W:  return XSEL_W;
            PORT_S:  return XSEL_S;
            PORT_L:  return XSEL_L;
            default: return XSEL_NONE;
        endcase
    endfunction

    // Port index k steps after base in rotation order.
    function automatic logic [2:0] rr_idx(logic [2:0] base, int k);
        return 3'((int'(base) + k) % NUM_PORTS);
    endfunction

    function automatic port_t onehot_to_port(logic [NUM_PORTS-1:0] oh);
        port_t p;
        p = PORT_L;
        for (int i = 0; i < NUM_PORTS; i++)
            if (oh[i]) p = port_t'(3'(i));
        return p;
    endfunction

endpackage

// File: rtl/credit_arbiter_if.sv
// Arbiter-facing bundle: per-input request/tail, downstream credit return,
// and the grant / crossbar select / credit status driven back.
interface credit_arbiter_if #(parameter int CW = 3);
    logic          Req_N, Req_E, Req_W, Req_S, Req_L;
    logic          Tail_N, Tail_E, Tail_W, Tail_S, Tail_L;
    logic          Credit_in;
    logic          Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
    logic [4:0]    Xbar_sel;
    logic          Valid_out;
    logic [CW-1:0] Credit_cnt;
    logic          Credit_err;

    modport master (
        output Req_N, Req_E, Req_W, Req_S, Req_L,
        output Tail_N, Tail_E, Tail_W, Tail_S, Tail_L,
        output Credit_in,
        input  Grant_N, Grant_E, Grant_W, Grant_S, Grant_L,
        input  Xbar_sel, Valid_out, Credit_cnt, Credit_err
    );

    modport slave (
        input  Req_N, Req_E, Req_W, Req_S, Req_L,
        input  Tail_N, Tail_E, Tail_W, Tail_S, Tail_L,
        input  Credit_in,
        output Grant_N, Grant_E, Grant_W, Grant_S, Grant_L,
        output Xbar_sel, Valid_out, Credit_cnt, Credit_err
    );
endinterface

// File: rtl/credit_arbiter_rr_pick.sv
// Combinational 5-way round-robin picker; the port after last_win has top
// priority. Shared with the input-side VC allocator.
module rr_pick
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_t                last_win,
    output logic [NUM_PORTS-1:0] win,
    output logic                 vld
);
    logic [2:0] idx;

    always_comb begin
        win = '0;
        vld = 1'b0;
        idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = rr_idx(last_win, k);
            if (!vld && req[idx]) begin
                win[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/credit_arbiter.sv
// Per-output arbiter: round-robin selection with wormhole locking and
// credit-based downstream flow control.
module credit_arbiter
    import router_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    credit_arbiter_if.slave  bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [NUM_PORTS-1:0] req, tail, grant, pick_oh;
    logic                 pick_vld, gnt_any;
    arb_state_t           state, state_nxt;
    port_t                owner, owner_nxt, last_win, last_win_nxt;
    logic [CW-1:0]        cnt;
    logic                 err;
    logic [NUM_PORTS-1:0] xsel;

    assign req  = {bus.Req_S,  bus.Req_W,  bus.Req_E,  bus.Req_N,  bus.Req_L};
    assign tail = {bus.Tail_S, bus.Tail_W, bus.Tail_E, bus.Tail_N, bus.Tail_L};

    rr_pick u_pick (
        .req      (req),
        .last_win (last_win),
        .win      (pick_oh),
        .vld      (pick_vld)
    );

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_win_nxt = last_win;
        grant        = '0;
        xsel         = XSEL_NONE;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = LOCKED;
                    owner_nxt = onehot_to_port(pick_oh);
                end
            end
            LOCKED: begin
                // Lock holds through bubbles and credit stalls until the tail pops.
                xsel = xsel_of(owner);
                if (req[owner] && cnt != '0) begin
                    grant[owner] = 1'b1;
                    if (tail[owner]) begin
                        state_nxt    = IDLE;
                        last_win_nxt = owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_any = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= PORT_L;
            last_win <= PORT_S;
            cnt      <= FULL;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_win <= last_win_nxt;
            if (bus.Credit_in && !gnt_any && cnt != FULL)
                cnt <= cnt + 1'b1;
            else if (gnt_any && !bus.Credit_in)
                cnt <= cnt - 1'b1;
            if (bus.Credit_in && cnt == FULL)
                err <= 1'b1;
        end
    end

    assign bus.Grant_L    = grant[PORT_L];
    assign bus.Grant_N    = grant[PORT_N];
    assign bus.Grant_E    = grant[PORT_E];
    assign bus.Grant_W    = grant[PORT_W];
    assign bus.Grant_S    = grant[PORT_S];
    assign bus.Xbar_sel   = xsel;
    assign bus.Valid_out  = gnt_any;
    assign bus.Credit_cnt = cnt;
    assign bus.Credit_err = err;
endmodule

// File: tb/tb_credit_arbiter.sv
// Bench for credit_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_credit_arbiter;
    localparam int CREDITS = 4;
    localparam int CW = $clog2(CREDITS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Port bit order in the bench: 0=L 1=N 2=E 3=W 4=S
    logic [4:0] req_v = '0;
    logic [4:0] tail_v = '0;
    logic       cr = 1'b0;
    logic [4:0] gnt_v;

    int n_pass = 0;
    int n_tot  = 0;

    credit_arbiter_if #(.CW(CW)) bus ();

    assign bus.Req_L = req_v[0];
    assign bus.Req_N = req_v[1];
    assign bus.Req_E = req_v[2];
    assign bus.Req_W = req_v[3];
    assign bus.Req_S = req_v[4];
    assign bus.Tail_L = tail_v[0];
    assign bus.Tail_N = tail_v[1];
    assign bus.Tail_E = tail_v[2];
    assign bus.Tail_W = tail_v[3];
    assign bus.Tail_S = tail_v[4];
    assign bus.Credit_in = cr;
    assign gnt_v = {bus.Grant_S, bus.Grant_W, bus.Grant_E, bus.Grant_N, bus.Grant_L};

    credit_arbiter #(.CREDITS(CREDITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: which port holds the output, who won last, credits left.
    bit         m_busy;
    int         m_owner, m_last, m_cred;
    bit         m_err;
    bit         e_g;
    logic [4:0] e_gnt, e_xsel;
    logic [4:0] xsel_tab [5] = '{5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_owner = 0; m_last = 4; m_cred = CREDITS; m_err = 0;
        end else begin
            e_g    = m_busy && req_v[m_owner] && (m_cred > 0);
            e_gnt  = e_g ? 5'(1 << m_owner) : 5'b0;
            e_xsel = m_busy ? xsel_tab[m_owner] : 5'b0;
            chk("m_grant",      gnt_v,          e_gnt);
            chk("m_xbar_sel",   bus.Xbar_sel,   e_xsel);
            chk("m_valid_out",  bus.Valid_out,  e_g);
            chk("m_credit_cnt", bus.Credit_cnt, m_cred);
            chk("m_credit_err", bus.Credit_err, m_err);
            if (!m_busy) begin
                for (int k = 1; k <= 5; k++)
                    if (!m_busy && req_v[(m_last + k) % 5]) begin
                        m_owner = (m_last + k) % 5;
                        m_busy  = 1;
                    end
            end else if (e_g && tail_v[m_owner]) begin
                m_busy = 0;
                m_last = m_owner;
            end
            if (cr && m_cred == CREDITS) m_err = 1;
            m_cred = m_cred + int'(cr) - int'(e_g);
            if (m_cred > CREDITS) m_cred = CREDITS;
        end
    end

    task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic c);
        @(posedge clk); #1;
        req_v = r; tail_v = t; cr = c;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_v = '0; tail_v = '0; cr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    int exp_w [6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] rr, rt;
    logic rc;

    initial begin
        // Two 1-flit packets, L then N
        do_reset();
        chk("rst_xsel", bus.Xbar_sel, 0);
        chk("rst_cnt", bus.Credit_cnt, 4);
        chk("rst_err", bus.Credit_err, 0);
        chk("rst_valid", bus.Valid_out, 0);
        drive(5'b00011, 5'b11111, 0); chk("t0_no_grant", gnt_v, 0);
        drive(5'b00011, 5'b11111, 0); chk("t1_xsel_L", bus.Xbar_sel, 5'b10000);
                                      chk("t1_grant_L", gnt_v, 5'b00001);
        drive(5'b00010, 5'b11111, 0); chk("t2_cnt", bus.Credit_cnt, 3);
                                      chk("t2_idle_xsel", bus.Xbar_sel, 0);
        drive(5'b00010, 5'b11111, 0); chk("t3_xsel_N", bus.Xbar_sel, 5'b00001);
                                      chk("t3_grant_N", gnt_v, 5'b00010);
        drive(5'b00000, 5'b00000, 0); chk("t4_cnt", bus.Credit_cnt, 2);
                                      chk("t4_model_cnt", m_cred, 2);

        // Credit exhaustion on an 8-flit packet
        do_reset();
        drive(5'b00001, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(5'b00001, 0, 0);
            chk("exh_grant", gnt_v, 5'b00001);
            chk("exh_cnt", bus.Credit_cnt, 4 - i);
        end
        drive(5'b00001, 0, 0); chk("exh_zero_cnt", bus.Credit_cnt, 0);
                               chk("exh_zero_grant", gnt_v, 0);
                               chk("exh_hold_xsel", bus.Xbar_sel, 5'b10000);
        drive(5'b00001, 0, 1); chk("cr1_same_cycle", gnt_v, 0);
        drive(5'b00001, 0, 0); chk("cr1_grant", gnt_v, 5'b00001);
        drive(5'b00001, 0, 0); chk("cr1_after", gnt_v, 0);
        drive(5'b00001, 0, 1); chk("cr2_same_cycle", gnt_v, 0);
        drive(5'b00001, 0, 0); chk("cr2_grant", gnt_v, 5'b00001);

        // E packet with a bubble while W waits
        do_reset();
        drive(5'b01100, 0, 0);
        drive(5'b01100, 0, 0);        chk("bub_e1", gnt_v, 5'b00100);
                                      chk("bub_xsel_E", bus.Xbar_sel, 5'b00010);
        drive(5'b01000, 0, 0);        chk("bub_none", gnt_v, 0);
                                      chk("bub_hold_E", bus.Xbar_sel, 5'b00010);
        drive(5'b01100, 0, 0);        chk("bub_e2", gnt_v, 5'b00100);
        drive(5'b01100, 5'b00100, 0); chk("bub_e3_tail", gnt_v, 5'b00100);
        drive(5'b01000, 0, 0);        chk("bub_gap", gnt_v, 0);
        drive(5'b01000, 5'b01000, 0); chk("bub_w", gnt_v, 5'b01000);
                                      chk("bub_xsel_W", bus.Xbar_sel, 5'b00100);

        // All five ports, 1-flit packets: rotation and one grant per 2 cycles
        do_reset();
        drive(5'b11111, 5'b11111, 0);
        for (int i = 0; i < 6; i++) begin
            drive(5'b11111, 5'b11111, 0); chk("rr_grant", gnt_v, 32'(1) << exp_w[i]);
            drive(5'b11111, 5'b11111, 1); chk("rr_gap", gnt_v, 0);
        end

        // Simultaneous grant+credit, then overflow
        do_reset();
        drive(5'b00001, 0, 0);
        drive(5'b00001, 0, 0);
        drive(5'b00001, 0, 0);
        drive(5'b00001, 0, 1); chk("both_pre_cnt", bus.Credit_cnt, 2);
                               chk("both_grant", gnt_v, 5'b00001);
        drive(5'b00000, 0, 0); chk("both_cnt", bus.Credit_cnt, 2);
        drive(5'b00000, 0, 1);
        drive(5'b00000, 0, 1);
        drive(5'b00000, 0, 1); chk("ovf_pre_cnt", bus.Credit_cnt, 4);
        drive(5'b00000, 0, 0); chk("ovf_cnt", bus.Credit_cnt, 4);
                               chk("ovf_err", bus.Credit_err, 1);
        drive(5'b00000, 0, 0); chk("ovf_err_sticky", bus.Credit_err, 1);
        do_reset();            chk("ovf_err_cleared", bus.Credit_err, 0);

        // Reset mid-packet with one credit left
        do_reset();
        drive(5'b00001, 0, 0);
        drive(5'b00001, 0, 0);
        drive(5'b00001, 0, 0);
        drive(5'b00001, 0, 0);
        drive(5'b00011, 0, 0); chk("mid_cnt1", bus.Credit_cnt, 1);
                               chk("mid_grant", gnt_v, 5'b00001);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("mid_rst_xsel", bus.Xbar_sel, 0);
        chk("mid_rst_grant", gnt_v, 0);
        chk("mid_rst_cnt", bus.Credit_cnt, 4);
        drive(5'b00011, 0, 0); chk("mid_L_first", bus.Xbar_sel, 5'b10000);

        // Randomized traffic; credits mostly legal, rare overflow
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rr = 5'($urandom);
            rt = '0;
            for (int p = 0; p < 5; p++) rt[p] = ($urandom_range(0, 3) == 0);
            if (m_cred < CREDITS) rc = ($urandom_range(0, 2) == 0);
            else                  rc = ($urandom_range(0, 199) == 0);
            drive(rr, rt, rc);
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/credit_arbiter.md
# credit_arbiter

Output-port arbiter for the 5-port mesh router (N, E, W, S, L). It shares one crossbar output between the five input FIFOs using round-robin priority with wormhole packet locking. Downstream flow control is credit-based (one credit per free downstream buffer slot) instead of the RTS/DCTS handshake. One instance sits per router output, driving the crossbar select and the per-input read grants.

## Interface
Parameters:
- CREDITS, 4: downstream buffer depth; legal range 1..15; counter width CW = $clog2(CREDITS+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Req_N, Req_E, Req_W, Req_S, Req_L  input  1 each  input FIFO non-empty and head flit routed to this output.
- Tail_N, Tail_E, Tail_W, Tail_S, Tail_L  input  1 each  head flit of that input is a packet tail; sampled only with its Req.
- Credit_in  input  1  one-cycle pulse; downstream freed one slot.
- Grant_N, Grant_E, Grant_W, Grant_S, Grant_L  output  1 each  pop one flit from that input this cycle; at most one asserted.
- Xbar_sel  output  5  one-hot crossbar select: N=00001, E=00010, W=00100, S=01000, L=10000; 00000 when idle.
- Valid_out  output  1  flit on crossbar output this cycle; equals OR of grants.
- Credit_cnt  output  CW  current credits available.
- Credit_err  output  1  sticky; Credit_in received while Credit_cnt == CREDITS.

## Operation
- State machine, registered: IDLE, LOCKED.
- Round-robin order L -> N -> E -> W -> S -> L. Highest priority goes to the port after last_win.
- IDLE:
  - Xbar_sel = 00000, no grants.
  - If any Req is high, the highest-priority requester is registered as owner and the FSM moves to LOCKED.
  - Otherwise the FSM stays in IDLE.
- LOCKED:
  - Xbar_sel = one-hot of owner.
  - Grant_owner = Req_owner && Credit_cnt != 0. The grant is combinational from the registered state, counter and Req.
  - A grant with Tail_owner high releases the lock: next state IDLE, last_win <= owner.
  - A grant without a tail keeps LOCKED.
  - Req_owner low (FIFO bubble) or Credit_cnt == 0 keeps LOCKED with no grant. The lock is never dropped mid-packet; requests on other ports are ignored.
- Credit counter:
  - Grant only: decrement.
  - Credit_in only: increment.
  - Grant and Credit_in in the same cycle: unchanged.
  - Credit_in at CREDITS: counter holds, Credit_err set. Only rst clears Credit_err.
  - Grant cannot occur at 0, so no underflow.
- Requests on ports other than the owner never affect grant, Xbar_sel or the counter.

## Timing
- Reset values:
  - state IDLE, last_win = S (L has top priority after reset).
  - Credit_cnt = CREDITS, Credit_err = 0.
  - All grants 0, Valid_out 0, Xbar_sel 00000.
- Reset mid-packet aborts the lock unconditionally and restores full credits.
- Arbitration latency: a request seen in IDLE at cycle t gives LOCKED with Xbar_sel valid at t+1. The first grant is at t+1 if Req and a credit are present.
- Throughput: one flit per cycle while locked with credits.
- Tail at cycle t returns to IDLE at t+1; re-arbitration happens at t+1 and the next grant is at t+2. This gives one idle cycle between packets by design.
- Credit_cnt updates at the edge after the grant or Credit_in cycle. A credit arriving at cycle t enables a grant at t+1.
- Single-flit packet: Req and Tail high together gives one grant and returns to IDLE next cycle.

## Structure
- Shared package router_pkg:
  - port index enum (PORT_L, PORT_N, PORT_E, PORT_W, PORT_S) and NUM_PORTS = 5;
  - one-hot Xbar select constants XSEL_N..XSEL_L and XSEL_NONE;
  - FSM enum arb_state_t {IDLE, LOCKED}.
- Sub-module rr_pick: combinational 5-way round-robin picker. Inputs are the request vector and last_win; outputs are the one-hot winner and the valid bit. It is reused by the input-side VC allocator.
- The counter, FSM and grant logic stay in credit_arbiter.

## Test plan
- Reset, then Req_N=Req_L=1, each sending a 1-flit packet -> L locked at t+1 with Xbar_sel=10000 and Grant_L; N granted at t+3 with Xbar_sel=00001; Credit_cnt 4->3->2.
- CREDITS=4, L sends an 8-flit packet, no Credit_in -> 4 grants, then Credit_cnt=0 with no grant and Xbar_sel held at 10000. Two Credit_in pulses -> 2 more grants, each one cycle after its credit.
- Req_E holds a 3-flit packet with a bubble (Req_E low one cycle) while Req_W is high -> no grant during the bubble and no switch to W; W is granted only after E's tail.
- All five requesting, 1-flit packets each, from reset -> grant order L, N, E, W, S, L, one grant every 2 cycles.
- Grant and Credit_in in the same cycle with Credit_cnt=2 -> stays 2. Credit_in at Credit_cnt=4 -> stays 4 and Credit_err=1 until rst.
- rst asserted mid-packet with Credit_cnt=1 -> next cycle IDLE, Credit_cnt=4, grants 0, Xbar_sel=00000, L again top priority.
